// File: rtl/gcd_pkg.sv
// Shared types for the GCD scheduler.
//   gcd_data : one requester's operand pair {a, b} at the default 8-bit width
//   state_e  : scheduler FSM states
package gcd_pkg;

    localparam int unsigned GCD_DW = 8;

    typedef struct packed {
        logic [GCD_DW-1:0] a;
        logic [GCD_DW-1:0] b;
    } gcd_data;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

endpackage

// File: rtl/gcd_core.sv
// Subtractive GCD datapath: one compare/subtract step per enabled cycle.
//   clk_i     : clock
//   nreset_i  : asynchronous active-low reset
//   load_i    : capture a_i/b_i and clear done
//   a_i, b_i  : operands
//   enable_i  : perform one step (ignored once done)
//   done_o    : result_o is valid (registered)
//   result_o  : gcd(a, b) (registered)
module gcd_core
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  enable_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] result_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            a_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (load_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            done_q <= 1'b0;
        end else if (enable_i && !done_q) begin
            if (a_q == '0 || b_q == '0) begin
                // gcd(x, 0) = x, and gcd(0, 0) collapses to 0
                done_q   <= 1'b1;
                result_q <= a_q | b_q;
            end else if (a_q == b_q) begin
                done_q   <= 1'b1;
                result_q <= a_q;
            end else if (a_q > b_q) begin
                a_q <= a_q - b_q;
            end else begin
                b_q <= b_q - a_q;
            end
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin front end sharing one GCD datapath between NUM_REQ requesters.
//   clk_i          : clock
//   nreset_i       : asynchronous active-low reset
//   req_valid_i    : per-requester request valid
//   req_ready_o    : per-requester accept strobe (one-hot winner in S_IDLE)
//   req_operands_i : per-requester {a, b}, a in the upper DATA_WIDTH bits
//   rsp_valid_o    : result available
//   rsp_ready_i    : consumer accepts the result
//   rsp_id_o       : requester owning the result
//   rsp_gcd_o      : gcd result
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned NUM_REQ    = 4,
    localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                                  clk_i,
    input  logic                                  nreset_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    input  logic [NUM_REQ-1:0][2*DATA_WIDTH-1:0]  req_operands_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [ID_WIDTH-1:0]                   rsp_id_o,
    output logic [DATA_WIDTH-1:0]                 rsp_gcd_o
);

    state_e                state_q;
    logic [ID_WIDTH-1:0]   rr_ptr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  run_q;
    logic                  rsp_valid_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_gcd_q;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   winner;
    logic                  any_valid;
    logic [ID_WIDTH:0]     scan_idx;
    logic [ID_WIDTH:0]     next_sum;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic                  accept;
    logic                  core_done;
    logic [DATA_WIDTH-1:0] core_result;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    // Scan upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(off);
            if (scan_idx >= (ID_WIDTH+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!any_valid && req_valid_i[scan_idx[ID_WIDTH-1:0]]) begin
                any_valid = 1'b1;
                winner    = scan_idx[ID_WIDTH-1:0];
            end
        end
        grant[winner] = any_valid;
    end

    always_comb begin
        next_sum = {1'b0, winner} + (ID_WIDTH+1)'(1);
        next_ptr = (next_sum == (ID_WIDTH+1)'(NUM_REQ)) ? '0 : next_sum[ID_WIDTH-1:0];
    end

    // run_q is low during reset and for the first edge after it, which keeps
    // ready low in reset without a combinational path from nreset_i.
    assign req_ready_o = (run_q && state_q == S_IDLE) ? grant : '0;
    assign accept      = |req_ready_o;

    assign sel_a = req_operands_i[winner][2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign sel_b = req_operands_i[winner][DATA_WIDTH-1:0];

    gcd_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .load_i   (accept),
        .a_i      (sel_a),
        .b_i      (sel_b),
        .enable_i (state_q == S_CALC),
        .done_o   (core_done),
        .result_o (core_result)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gcd_q   <= '0;
        end else begin
            run_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        id_q     <= winner;
                        rr_ptr_q <= next_ptr;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (core_done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_gcd_q   <= core_result;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_gcd_o   = rsp_gcd_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Scoreboard bench for gcd_scheduler: requests push expected responses, a
// monitor pops and compares each response the consumer accepts.
module tb_gcd_scheduler;
    import gcd_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;

    logic                       clk = 1'b0;
    logic                       nreset = 1'b0;
    logic [NR-1:0]              req_valid = '0;
    logic [NR-1:0]              req_ready;
    logic [NR-1:0][2*DW-1:0]    req_ops = '0;
    logic                       rsp_valid;
    logic                       rsp_ready = 1'b1;
    logic [IW-1:0]              rsp_id;
    logic [DW-1:0]              rsp_gcd;

    gcd_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk_i          (clk),
        .nreset_i       (nreset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_operands_i (req_ops),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_gcd_o      (rsp_gcd)
    );

    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int id;
        int g;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   exp_grants[11] = '{0, 1, 2, 3, 0, 1, 2, 3, 2, 0, 3};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Raise a request, wait for the grant, and log the expected response.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input int g, input int lat);
        gcd_data d;
        bit      ok;
        exp_t    e;
        ok  = 1'b0;
        d.a = a;
        d.b = b;
        @(negedge clk);
        req_ops[id]   = d;
        req_valid[id] = 1'b1;
        for (int t = 0; t < 2000 && !ok; t++) begin
            #1;
            if (req_ready[id]) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            expired("grant_wait");
            req_valid[id] = 1'b0;
            return;
        end
        e.id  = id;
        e.g   = g;
        e.lat = lat;
        e.acc = int'(cycle) + 1;
        exp_q.push_back(e);
        grant_log.push_back(id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || rsp_valid) expired("drain_wait");
    endtask

    initial begin : monitor
        logic prev;
        int   first;
        exp_t e;
        prev  = 1'b0;
        first = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid && !prev) first = int'(cycle);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp_id", int'(rsp_id), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", int'(rsp_id), e.id);
                    check("rsp_gcd", int'(rsp_gcd), e.g);
                    check("rsp_latency", first - e.acc, e.lat);
                end
            end
            prev = rsp_valid;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;

        // Reset with every requester asserting valid.
        nreset    = 1'b0;
        req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", int'(req_ready), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_gcd", int'(rsp_gcd), 0);
        nreset = 1'b1;

        // Round 1 from reset: grants 0,1,2,3. (12,18) takes two subtractions.
        fork
            issue(0, 8'd12, 8'd18, 6, 4);
            issue(1, 8'd0,  8'd9,  9, 2);
            issue(2, 8'd0,  8'd0,  0, 2);
            issue(3, 8'd7,  8'd7,  7, 2);
        join

        // Round 2 wraps back to 0; (255,1) needs 254 subtractions.
        fork
            issue(1, 8'd9,   8'd6, 3, 4);
            issue(0, 8'd255, 8'd1, 1, 256);
        join
        wait_drain(1000);

        // Consumer stalls for 5 cycles while requester 3 stays pending.
        rsp_ready = 1'b0;
        fork
            issue(2, 8'd21, 8'd14, 7, 4);
            issue(3, 8'd15, 8'd10, 5, 4);
        join_none
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) expired("stall_rsp_wait");
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", int'(rsp_valid), 1);
            check("stall_rsp_id", int'(rsp_id), 2);
            check("stall_rsp_gcd", int'(rsp_gcd), 7);
            check("stall_req_ready", int'(req_ready), 0);
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        wait fork;
        wait_drain(200);

        // Reset in the middle of computing (48,36).
        issue(2, 8'd48, 8'd36, 12, 5);
        @(negedge clk);
        nreset       = 1'b0;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        #1;
        check("midreset_rsp_valid", int'(rsp_valid), 0);
        check("midreset_rsp_gcd", int'(rsp_gcd), 0);
        check("midreset_req_ready", int'(req_ready), 0);
        exp_q.delete();
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("post_reset_rsp_valid", int'(rsp_valid), 0);
        // rr_ptr back at 0: requester 0 must beat requester 3.
        fork
            issue(3, 8'd8,  8'd12, 4, 4);
            issue(0, 8'd48, 8'd36, 12, 5);
        join
        wait_drain(200);

        check("grant_count", grant_log.size(), 11);
        for (int i = 0; i < 11 && i < grant_log.size(); i++) begin
            check("grant_order", grant_log[i], exp_grants[i]);
        end
        check("scoreboard_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
